// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the 16x oversampling UART.
package uart_pkg;

    localparam int unsigned OS_RATE    = 16;
    localparam int unsigned SAMPLE_MID = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CFG_BITS_W = 2;
    localparam int unsigned NBITS_W    = 4;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'b00,
        BAUD_19200  = 2'b01,
        BAUD_57600  = 2'b10,
        BAUD_115200 = 2'b11
    } baud_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              parity_err;
        logic              frame_err;
    } rx_frame_t;

    function automatic int unsigned baud_rate(input baud_t b);
        case (b)
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            BAUD_57600:  return 57600;
            default:     return 115200;
        endcase
    endfunction

    // Rounded clk cycles per oversample tick.
    function automatic int unsigned divisor(input int unsigned clk_freq, input baud_t b);
        int unsigned tick_rate;
        tick_rate = OS_RATE * baud_rate(b);
        return (clk_freq + tick_rate / 2) / tick_rate;
    endfunction

    function automatic logic [NBITS_W-1:0] num_bits(input logic [CFG_BITS_W-1:0] cfg_bits);
        return NBITS_W'(5) + NBITS_W'(cfg_bits);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: one-clk tick every round(CLK_FREQ/(16*baud)) clocks,
// restartable so the tick phase can be aligned to an external event.
module uart_os_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_cfg_baud,
    input  logic       i_restart,
    output logic       o_tick
);

    localparam int unsigned DIV_9600   = divisor(CLK_FREQ, BAUD_9600);
    localparam int unsigned DIV_19200  = divisor(CLK_FREQ, BAUD_19200);
    localparam int unsigned DIV_57600  = divisor(CLK_FREQ, BAUD_57600);
    localparam int unsigned DIV_115200 = divisor(CLK_FREQ, BAUD_115200);
    localparam int unsigned CNT_W      = $clog2(DIV_9600 + 1);

    localparam logic [CNT_W-1:0] LAST_9600   = CNT_W'(DIV_9600 - 1);
    localparam logic [CNT_W-1:0] LAST_19200  = CNT_W'(DIV_19200 - 1);
    localparam logic [CNT_W-1:0] LAST_57600  = CNT_W'(DIV_57600 - 1);
    localparam logic [CNT_W-1:0] LAST_115200 = CNT_W'(DIV_115200 - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;

    always_comb begin
        w_last = LAST_9600;
        case (baud_t'(i_cfg_baud))
            BAUD_9600:   w_last = LAST_9600;
            BAUD_19200:  w_last = LAST_19200;
            BAUD_57600:  w_last = LAST_57600;
            BAUD_115200: w_last = LAST_115200;
            default:     w_last = LAST_9600;
        endcase
    end

    // >= rather than == so a baud change while running can never skip the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
        end else if (i_restart) begin
            r_cnt  <= '0;
            o_tick <= 1'b0;
        end else if (r_cnt >= w_last) begin
            r_cnt  <= '0;
            o_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver with 16x oversampling, 3-sample mid-bit majority vote, even parity
// and stop-bit checking, and a valid/ready output register with overrun reporting.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx_en,
    input  logic              i_rx_serial,
    input  logic              i_cfg_parity,
    input  logic [1:0]        i_cfg_bits,
    input  logic [1:0]        i_cfg_baud,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_rx_busy
);

    localparam logic [3:0] S_VOTE0   = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] S_VOTE1   = 4'(SAMPLE_MID);
    localparam logic [3:0] S_RESOLVE = 4'(SAMPLE_MID + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    rx_state_t              r_state;
    logic [3:0]             r_s;
    logic [1:0]             r_vote;
    logic [NBITS_W-1:0]     r_bit_idx;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_par_acc;
    logic                   r_perr;
    logic [NBITS_W-1:0]     r_nbits;
    logic                   r_par_en;
    baud_t                  r_baud;
    logic                   r_done;
    rx_frame_t              r_done_frame;

    logic w_rx;
    logic w_fall;
    logic w_restart;
    logic w_tick;
    logic w_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_serial};
        end
    end

    assign w_rx      = r_sync[SYNC_STAGES-1];
    assign w_fall    = r_rx_prev & ~w_rx;
    assign w_restart = (r_state == IDLE) & i_rx_en & w_fall;
    assign w_bit     = majority3(r_vote[0], r_vote[1], w_rx);

    uart_os_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .i_cfg_baud (r_baud),
        .i_restart  (w_restart),
        .o_tick     (w_tick)
    );

    // Frame FSM: every bit is resolved at s = 9 from the votes at s = 7, 8 and 9.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rx_prev    <= 1'b1;
            r_s          <= '0;
            r_vote       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_perr       <= 1'b0;
            r_nbits      <= '0;
            r_par_en     <= 1'b0;
            r_baud       <= BAUD_9600;
            r_done       <= 1'b0;
            r_done_frame <= '0;
            o_rx_busy    <= 1'b0;
        end else begin
            r_rx_prev <= w_rx;
            r_done    <= 1'b0;
            if (!i_rx_en) begin
                r_state   <= IDLE;
                o_rx_busy <= 1'b0;
            end else if (r_state == IDLE) begin
                if (w_fall) begin
                    r_state   <= START;
                    o_rx_busy <= 1'b1;
                    r_s       <= '0;
                    r_bit_idx <= '0;
                    r_shift   <= '0;
                    r_par_acc <= 1'b0;
                    r_perr    <= 1'b0;
                    r_nbits   <= num_bits(i_cfg_bits);
                    r_par_en  <= i_cfg_parity;
                    r_baud    <= baud_t'(i_cfg_baud);
                end
            end else if (w_tick) begin
                r_s <= r_s + 4'd1;
                if (r_s == S_VOTE0) r_vote[0] <= w_rx;
                if (r_s == S_VOTE1) r_vote[1] <= w_rx;
                if (r_s == S_RESOLVE) begin
                    case (r_state)
                        START: begin
                            if (w_bit) begin
                                r_state   <= IDLE;
                                o_rx_busy <= 1'b0;
                            end else begin
                                r_state <= DATA;
                            end
                        end
                        DATA: begin
                            r_shift   <= {w_bit, r_shift[DATA_W-1:1]};
                            r_par_acc <= r_par_acc ^ w_bit;
                            r_bit_idx <= r_bit_idx + NBITS_W'(1);
                            if (r_bit_idx == r_nbits - NBITS_W'(1)) begin
                                r_state <= r_par_en ? PARITY : STOP;
                            end
                        end
                        PARITY: begin
                            r_perr  <= r_par_acc ^ w_bit;
                            r_state <= STOP;
                        end
                        STOP: begin
                            // Short frames land in the top bits; shift down to [N-1:0].
                            r_done                  <= 1'b1;
                            r_done_frame.data       <= r_shift >> (NBITS_W'(DATA_W) - r_nbits);
                            r_done_frame.parity_err <= r_perr;
                            r_done_frame.frame_err  <= ~w_bit;
                            r_state                 <= IDLE;
                            o_rx_busy               <= 1'b0;
                        end
                        default: begin
                            r_state   <= IDLE;
                            o_rx_busy <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rx_data    <= '0;
            o_rx_valid   <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (r_done) begin
                if (!o_rx_valid || i_rx_ready) begin
                    o_rx_data    <= r_done_frame.data;
                    o_parity_err <= r_done_frame.parity_err;
                    o_frame_err  <= r_done_frame.frame_err;
                    o_rx_valid   <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- Robust UART receiver for the far end of the `uart_tx` serial line.
- Samples at 16x the baud rate and takes a 3-sample majority vote at mid-bit.
- Checks even parity and the stop bit, then presents each byte on a valid/ready handshake with error flags.
- Intended for the board-facing RX pin, where the simple receiver is too sensitive to glitches and has no back-pressure.

Parameters:
- CLK_FREQ, 100_000_000: system clock in Hz. Used to derive the oversample divisors.
- SYNC_STAGES, 2: number of flip-flops in the input synchronizer on i_rx_serial. Minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset. Asynchronous assert and deassert, active-high.
- i_rx_en  in  1  receiver enable
- i_rx_serial  in  1  serial line input, asynchronous. Idle level is 1.
- i_cfg_parity  in  1  1 = even parity bit present, 0 = no parity
- i_cfg_bits  in  2  data bits: 00=5, 01=6, 10=7, 11=8
- i_cfg_baud  in  2  00=9600, 01=19200, 10=57600, 11=115200
- o_rx_data  out  8  received byte, right-justified, unused MSBs are 0
- o_rx_valid  out  1  o_rx_data and error flags are valid
- i_rx_ready  in  1  consumer accepts the byte
- o_parity_err  out  1  parity mismatch, qualified by o_rx_valid
- o_frame_err  out  1  stop bit sampled as 0, qualified by o_rx_valid
- o_overrun  out  1  one-cycle pulse when a completed frame is dropped
- o_rx_busy  out  1  FSM is not in IDLE

Behaviour:
- Reset values:
  - all outputs are 0.
  - synchronizer flops are 1.
  - FSM is in IDLE.
  - counters are 0.
- Tick generator:
  - Divisor DIV = round(CLK_FREQ/(16*baud)). At 100 MHz this gives 651, 326, 109, 54.
  - A free counter counts 0..DIV-1 and pulses `tick` for one clk at DIV-1.
  - The counter restarts at 0 on start-edge detection, so sampling stays phase-aligned to the frame.
- Majority vote:
  - Within each bit, a 4-bit sample index s counts 0..15 on ticks.
  - Samples taken at s = 7, 8, 9; the bit value is the majority of the three.
  - The bit is resolved at s = 9.
- FSM states and transitions:
  - IDLE -> START: on synchronized 1->0 with i_rx_en=1. Latch the cfg inputs into frame registers here; cfg changes mid-frame are ignored.
  - START -> DATA: majority 0. START -> IDLE: majority 1 (false start, nothing reported).
  - DATA: receives N bits, LSB first, into a shift register.
  - DATA -> PARITY: after bit N-1, if parity is enabled. Otherwise DATA -> STOP.
  - PARITY: parity_err = (XOR of the N data bits) XOR (received bit).
  - STOP: frame_err = (majority == 0). At s=9 the frame completes and the FSM returns to IDLE. It does not wait the remaining half bit, so back-to-back frames are caught.
- Bit alignment:
  - Short frames are shifted so data occupies [N-1:0].
  - Bits [7:N] are 0.
- Output register / handshake:
  - On completion with o_rx_valid=0: load data and flags, and o_rx_valid=1 on the next cycle.
  - A transfer occurs on o_rx_valid && i_rx_ready. o_rx_valid drops the next cycle.
  - Transfer and completion in the same cycle: the new frame loads and o_rx_valid stays 1.
  - Completion while o_rx_valid=1 and no transfer that cycle: the new frame is discarded, o_overrun pulses for 1 clk, and held data is unchanged.
  - o_rx_data and flags are stable while o_rx_valid=1.
- i_rx_en=0:
  - Forces the FSM to IDLE within 1 clk and discards any partial frame.
  - The output register and o_rx_valid are retained.
  - Start edges are ignored.
- A line held low after a frame error does not retrigger until a 1 is seen; start detection is edge-based.
- Async rst mid-frame: immediate return to reset values, including dropping o_rx_valid.

Decomposition:
- Package uart_pkg:
  - baud enum, decoded from i_cfg_baud
  - function divisor(CLK_FREQ, baud)
  - function num_bits(cfg_bits) -> 5..8
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - constants OS_RATE=16, SAMPLE_MID=8
- Sub-module uart_os_tick_gen: clk, rst, i_cfg_baud, i_restart -> o_tick. It is reusable by a future oversampling transmitter.

Test Plan:
- 8E1, 115200, byte 0xA6 (parity bit 0), driven by `uart_tx` in loopback with i_rx_ready=1 -> o_rx_valid pulses once, o_rx_data=0xA6, both error flags 0. Frame length is 11 bits x 864 clk.
- 5N1, 9600, byte 0x15 -> o_rx_data=0x15 with bits [7:5]=0. Then 8E1 0x3C with a wrong parity bit 1 -> o_parity_err=1, o_rx_data=0x3C.
- Stop bit forced 0 on 0x55 8N1 -> o_frame_err=1. A 1-clk-wide and then a 5-tick-wide low glitch on the idle line -> no o_rx_valid and the FSM is back in IDLE.
- Two back-to-back frames 0x11, 0x22 with i_rx_ready=0 -> 0x11 is held, o_overrun pulses once at the second stop-bit sample. Raise ready -> 0x11 transfers and 0x22 is never presented.
- One midbit sample (s=8) inverted on each data bit of 0xA5 -> majority recovers 0xA5 with no errors.
- i_rx_en dropped mid-DATA, then rst pulsed mid-frame -> FSM goes to IDLE, no valid, o_rx_busy=0. After rst: all outputs are 0 and the next frame 0x7E is received correctly.
